aliens_io_regs: RTL and testbench
=================================

Name: aliens_io_regs

Overview:
- I/O register block sitting directly downstream of the k053327 address-decode PAL; consumes its active-low IOCS strobe together with the CPU address, data and R/W.
- Holds the write-side control registers: bank/control, coin counters and sound command latch.
- Provides the registered read mux for player inputs and DIP switches, a sound-CPU IRQ handshake and a watchdog that asserts system reset when not kicked.

Parameters:
- WDT_MAX, 24'd3000000, watchdog timeout in clk cycles without a kick.
- COIN_PULSE, 16'd50000, minimum coin-counter output high time in clk cycles.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- iocs_n  in  1  I/O chip select from decode PAL (IOCS), active low.
- rw  in  1  CPU R/W; 1 = read, 0 = write.
- addr  in  3  CPU ADDR[2:0].
- din  in  8  CPU write data.
- dout  out  8  registered read data.
- p1, p2  in  8 each  player inputs, active low.
- dsw1, dsw2  in  8 each  DIP switches.
- dsw3  in  4  DIP bank 3 (low nibble).
- ctrl  out  8  bank/control register.
- coin_ctr  out  2  coin counter drive.
- snd_cmd  out  8  sound command latch.
- snd_irq  out  1  IRQ to sound CPU, active high.
- snd_ack  in  1  sound CPU acknowledge pulse.
- wdt_rst  out  1  watchdog reset request, active high.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n). All state resets to 0: dout=8'h00, ctrl=8'h00, coin_ctr=2'b00, snd_cmd=8'h00, snd_irq=0, wdt_rst=0, watchdog and coin counters cleared.
- Access detect: iocs_n is registered once (cs_q). An access event is the cycle where iocs_n=0 and cs_q=1, i.e. the falling edge. Exactly one event per low period, however long iocs_n stays low.
- Write on event with rw=0:
  - addr 0 -> ctrl<=din.
  - addr 1 -> coin request bits <= din[1:0]; also a watchdog kick.
  - addr 4 -> snd_cmd<=din, snd_irq<=1.
  - Other addresses are ignored.
- Read on event with rw=1: dout is loaded the next cycle (1-cycle latency) and holds until the next read event.
  - addr 0 -> {4'hF,dsw3}.
  - addr 1 -> p1.
  - addr 2 -> p2.
  - addr 3 -> dsw2.
  - addr 4 -> dsw1.
  - Other addresses -> 8'hFF.
- Sound handshake:
  - snd_irq stays set until snd_ack is sampled high; then it clears on the next clk.
  - If a write to addr 4 coincides with snd_ack, the write wins: snd_irq=1 and snd_cmd is updated.
  - A second write while snd_irq=1 overwrites snd_cmd; snd_irq stays 1.
- Coin counters, per bit n, state machine IDLE/PULSE:
  - IDLE -> PULSE on a 0->1 transition of request bit n. The counter loads COIN_PULSE-1 and coin_ctr[n]=1.
  - PULSE decrements each cycle and returns to IDLE at 0 only if request bit n is 0. Otherwise it holds coin_ctr[n]=1 until the request clears.
  - Result: the high time is at least COIN_PULSE cycles. A new rising request while in PULSE does not restart the count.
- Watchdog:
  - The 24-bit counter increments every cycle and clears on a kick.
  - When the counter reaches WDT_MAX-1, wdt_rst=1 for exactly one cycle and the counter clears.
  - A kick in the same cycle as expiry suppresses wdt_rst.
- Reset mid-operation: rst_n low during an access, pulse or pending IRQ clears everything immediately. After release, an iocs_n already held low does not generate an event, because cs_q resets to 0.

Test Plan:
- Write sequence: reset, then iocs_n low with rw=0, addr=0, din=8'hA5 -> ctrl=8'hA5 two clks after the falling edge. Holding iocs_n low for 10 clks causes no further writes; ctrl is unchanged when din changes to 8'h00 mid-access.
- Read mux: p1=8'hFE, dsw3=4'h7, then read addr 1 -> dout=8'hFE one clk after the event. Read addr 0 -> dout=8'hF7. Read addr 6 -> dout=8'hFF.
- Sound handshake: write 8'h3C to addr 4 -> snd_cmd=8'h3C, snd_irq=1. snd_ack pulse -> snd_irq=0 next clk. A write coinciding with snd_ack -> snd_irq remains 1.
- Coin counter: with COIN_PULSE=8, a 1-clk request on bit0 -> coin_ctr[0] high exactly 8 clks. A request held 20 clks -> high 20 clks. Bit1 remains independent.
- Watchdog: with WDT_MAX=16, no kicks -> wdt_rst 1-clk pulse every 16 clks. A kick on the expiry cycle -> no pulse. Assert rst_n low mid-count -> counter restarts from 0.

Source files
------------

// File: rtl/aliens_io_regs.sv
// I/O register block behind the k053327 decode PAL: control/coin/sound write
// registers, registered input read mux, sound IRQ handshake and watchdog.
module aliens_io_regs #(
  parameter logic [23:0] WDT_MAX    = 24'd3000000,
  parameter logic [15:0] COIN_PULSE = 16'd50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs_n,
  input  logic       rw,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic [7:0] p1,
  input  logic [7:0] p2,
  input  logic [7:0] dsw1,
  input  logic [7:0] dsw2,
  input  logic [3:0] dsw3,
  output logic [7:0] ctrl,
  output logic [1:0] coin_ctr,
  output logic [7:0] snd_cmd,
  output logic       snd_irq,
  input  logic       snd_ack,
  output logic       wdt_rst
);

  typedef enum logic {C_IDLE, C_PULSE} coin_state_t;

  logic        cs_q;
  logic        ev, wr_ev, rd_ev, kick;
  logic        rd_vld_p1;
  logic [2:0]  rd_addr_p1;
  logic [7:0]  rd_data;
  logic [1:0]  req, req_prev;
  logic [23:0] wdt_cnt;

  coin_state_t cstate     [2];
  coin_state_t cstate_nxt [2];
  logic [15:0] ccnt       [2];
  logic [15:0] ccnt_nxt   [2];

  // One event per low period of iocs_n; cs_q resets low so a strobe already
  // held low when reset releases never fires.
  assign ev    = ~iocs_n & cs_q;
  assign wr_ev = ev & ~rw;
  assign rd_ev = ev & rw;
  assign kick  = wr_ev & (addr == 3'd1);

  always_comb begin
    rd_data = 8'hFF;
    case (rd_addr_p1)
      3'd0:    rd_data = {4'hF, dsw3};
      3'd1:    rd_data = p1;
      3'd2:    rd_data = p2;
      3'd3:    rd_data = dsw2;
      3'd4:    rd_data = dsw1;
      default: rd_data = 8'hFF;
    endcase
  end

  // Stage p0: access decode; stage p1: read data load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q       <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_addr_p1 <= 3'd0;
      dout       <= 8'h00;
      ctrl       <= 8'h00;
      req        <= 2'b00;
      req_prev   <= 2'b00;
      snd_cmd    <= 8'h00;
      snd_irq    <= 1'b0;
      wdt_cnt    <= 24'd0;
      wdt_rst    <= 1'b0;
    end else begin
      cs_q      <= iocs_n;
      rd_vld_p1 <= rd_ev;
      if (rd_ev) rd_addr_p1 <= addr;
      if (rd_vld_p1) dout <= rd_data;

      req_prev <= req;
      if (wr_ev && addr == 3'd0) ctrl <= din;
      if (kick) req <= din[1:0];

      // A new command outranks an acknowledge arriving in the same cycle.
      if (wr_ev && addr == 3'd4) begin
        snd_cmd <= din;
        snd_irq <= 1'b1;
      end else if (snd_ack) begin
        snd_irq <= 1'b0;
      end

      if (kick) begin
        wdt_cnt <= 24'd0;
        wdt_rst <= 1'b0;
      end else if (wdt_cnt == WDT_MAX - 24'd1) begin
        wdt_cnt <= 24'd0;
        wdt_rst <= 1'b1;
      end else begin
        wdt_cnt <= wdt_cnt + 24'd1;
        wdt_rst <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        cstate[n] <= C_IDLE;
        ccnt[n]   <= 16'd0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        cstate[n] <= cstate_nxt[n];
        ccnt[n]   <= ccnt_nxt[n];
      end
    end
  end

  // Coin pulse stretches to COIN_PULSE cycles, or longer while request holds.
  always_comb begin
    coin_ctr = 2'b00;
    for (int n = 0; n < 2; n++) begin
      cstate_nxt[n] = cstate[n];
      ccnt_nxt[n]   = ccnt[n];
      case (cstate[n])
        C_IDLE: begin
          if (req[n] && !req_prev[n]) begin
            cstate_nxt[n] = C_PULSE;
            ccnt_nxt[n]   = COIN_PULSE - 16'd1;
          end
        end
        C_PULSE: begin
          coin_ctr[n] = 1'b1;
          if (ccnt[n] != 16'd0) ccnt_nxt[n] = ccnt[n] - 16'd1;
          else if (!req[n])     cstate_nxt[n] = C_IDLE;
        end
        default: cstate_nxt[n] = C_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aliens_io_regs.sv
// Bench for aliens_io_regs: directed tables and sequences, then random traffic
// compared cycle by cycle against an event-level reference model.
module tb_aliens_io_regs;

  localparam logic [23:0] WDT_M = 24'd16;
  localparam logic [15:0] CP    = 16'd8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iocs_n = 1'b1;
  logic       rw = 1'b1;
  logic [2:0] addr = 3'd0;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic [7:0] p1 = 8'hFF, p2 = 8'hFF, dsw1 = 8'h00, dsw2 = 8'h00;
  logic [3:0] dsw3 = 4'h0;
  logic [7:0] ctrl;
  logic [1:0] coin_ctr;
  logic [7:0] snd_cmd;
  logic       snd_irq;
  logic       snd_ack = 1'b0;
  logic       wdt_rst;

  aliens_io_regs #(.WDT_MAX(WDT_M), .COIN_PULSE(CP)) dut (
    .clk(clk), .rst_n(rst_n), .iocs_n(iocs_n), .rw(rw), .addr(addr),
    .din(din), .dout(dout), .p1(p1), .p2(p2), .dsw1(dsw1), .dsw2(dsw2),
    .dsw3(dsw3), .ctrl(ctrl), .coin_ctr(coin_ctr), .snd_cmd(snd_cmd),
    .snd_irq(snd_irq), .snd_ack(snd_ack), .wdt_rst(wdt_rst)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int hi0 = 0, hi1 = 0;
  bit chk_model = 1'b0;

  // Reference model state
  bit         m_cs;
  logic [7:0] m_ctrl, m_cmd, m_dout;
  bit         m_irq, m_wdt;
  bit [1:0]   m_req, m_req_old, m_hi;
  int         m_start [2];
  int         m_cyc, m_base;
  int         rdq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_read(input int a);
    case (a)
      0: return {4'hF, dsw3};
      1: return p1;
      2: return p2;
      3: return dsw2;
      4: return dsw1;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic model_reset();
    m_cs = 0; m_ctrl = 0; m_cmd = 0; m_dout = 0; m_irq = 0; m_wdt = 0;
    m_req = 0; m_req_old = 0; m_hi = 0; m_start[0] = 0; m_start[1] = 0;
    m_cyc = 0; m_base = 0;
    rdq.delete();
  endtask

  task automatic model_edge();
    bit ev, wr, rd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev = !iocs_n && m_cs;
    wr = ev && !rw;
    rd = ev && rw;
    if (rdq.size() > 0) m_dout = ref_read(rdq.pop_front());
    if (rd) rdq.push_back(int'(addr));
    for (int n = 0; n < 2; n++) begin
      if (!m_hi[n] && m_req[n] && !m_req_old[n]) begin
        m_hi[n] = 1; m_start[n] = m_cyc;
      end else if (m_hi[n] && (m_cyc - m_start[n]) >= int'(CP) && !m_req[n]) begin
        m_hi[n] = 0;
      end
    end
    m_req_old = m_req;
    if (wr && addr == 3'd1) m_req = din[1:0];
    if (wr && addr == 3'd4) begin m_cmd = din; m_irq = 1; end
    else if (snd_ack) m_irq = 0;
    if (wr && addr == 3'd0) m_ctrl = din;
    if (wr && addr == 3'd1) begin m_base = m_cyc + 1; m_wdt = 0; end
    else if (m_cyc - m_base == int'(WDT_M) - 1) begin m_base = m_cyc + 1; m_wdt = 1; end
    else m_wdt = 0;
    m_cs = iocs_n;
    m_cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (coin_ctr[0]) hi0++;
    if (coin_ctr[1]) hi1++;
    if (chk_model) begin
      chk("rnd_dout", 32'(dout), 32'(m_dout));
      chk("rnd_ctrl", 32'(ctrl), 32'(m_ctrl));
      chk("rnd_coin", 32'(coin_ctr), 32'({m_hi[1], m_hi[0]}));
      chk("rnd_cmd",  32'(snd_cmd), 32'(m_cmd));
      chk("rnd_irq",  32'(snd_irq), 32'(m_irq));
      chk("rnd_wdt",  32'(wdt_rst), 32'(m_wdt));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    iocs_n = 1'b0; rw = 1'b0; addr = a; din = d;
    step();
    iocs_n = 1'b1;
    step();
  endtask

  task automatic rd(input logic [2:0] a);
    iocs_n = 1'b0; rw = 1'b1; addr = a;
    step();
    iocs_n = 1'b1;
    step();
  endtask

  typedef struct {
    logic [2:0] a;
    logic [7:0] v1, v2, s1, s2;
    logic [3:0] s3;
    logic [7:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d, exp_ctrl, exp_cmd;
  } wr_vec_t;

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rd_vec_t rv [8];
    wr_vec_t wv [5];
    int pulses, first;

    rv[0] = '{3'd1, 8'hFE, 8'h00, 8'h00, 8'h00, 4'h7, 8'hFE};
    rv[1] = '{3'd0, 8'hFE, 8'h00, 8'h00, 8'h00, 4'h7, 8'hF7};
    rv[2] = '{3'd6, 8'hFE, 8'h00, 8'h00, 8'h00, 4'h7, 8'hFF};
    rv[3] = '{3'd2, 8'h00, 8'h5A, 8'h00, 8'h00, 4'h0, 8'h5A};
    rv[4] = '{3'd3, 8'h00, 8'h00, 8'h00, 8'hC3, 4'h0, 8'hC3};
    rv[5] = '{3'd4, 8'h00, 8'h00, 8'h81, 8'h00, 4'h0, 8'h81};
    rv[6] = '{3'd5, 8'h12, 8'h34, 8'h56, 8'h78, 4'h9, 8'hFF};
    rv[7] = '{3'd0, 8'h12, 8'h34, 8'h56, 8'h78, 4'h0, 8'hF0};

    wv[0] = '{3'd0, 8'h3C, 8'h3C, 8'h00};
    wv[1] = '{3'd2, 8'hFF, 8'h3C, 8'h00};
    wv[2] = '{3'd4, 8'h5A, 8'h3C, 8'h5A};
    wv[3] = '{3'd7, 8'h11, 8'h3C, 8'h5A};
    wv[4] = '{3'd0, 8'h00, 8'h00, 8'h5A};

    do_reset();
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_ctrl", 32'(ctrl), 32'h00);
    chk("rst_coin", 32'(coin_ctr), 32'h0);
    chk("rst_cmd",  32'(snd_cmd), 32'h00);
    chk("rst_irq",  32'(snd_irq), 32'h0);
    chk("rst_wdt",  32'(wdt_rst), 32'h0);

    // Write with a long low strobe: only the falling edge writes
    step();
    iocs_n = 1'b0; rw = 1'b0; addr = 3'd0; din = 8'hA5;
    step(); step();
    chk("wr_ctrl", 32'(ctrl), 32'hA5);
    din = 8'h00;
    repeat (10) step();
    chk("wr_hold", 32'(ctrl), 32'hA5);
    iocs_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      wr(wv[i].a, wv[i].d);
      chk($sformatf("wtab%0d_ctrl", i), 32'(ctrl), 32'(wv[i].exp_ctrl));
      chk($sformatf("wtab%0d_cmd", i), 32'(snd_cmd), 32'(wv[i].exp_cmd));
    end

    for (int i = 0; i < 8; i++) begin
      p1 = rv[i].v1; p2 = rv[i].v2; dsw1 = rv[i].s1; dsw2 = rv[i].s2; dsw3 = rv[i].s3;
      rd(rv[i].a);
      chk($sformatf("rtab%0d_dout", i), 32'(dout), 32'(rv[i].exp));
    end

    // Sound handshake
    wr(3'd4, 8'h3C);
    chk("snd_cmd", 32'(snd_cmd), 32'h3C);
    chk("snd_irq_set", 32'(snd_irq), 32'h1);
    snd_ack = 1'b1; step(); snd_ack = 1'b0;
    chk("snd_irq_ack", 32'(snd_irq), 32'h0);
    step();
    iocs_n = 1'b0; rw = 1'b0; addr = 3'd4; din = 8'hC3; snd_ack = 1'b1;
    step();
    snd_ack = 1'b0; iocs_n = 1'b1;
    chk("snd_coinc_irq", 32'(snd_irq), 32'h1);
    chk("snd_coinc_cmd", 32'(snd_cmd), 32'hC3);
    step();
    wr(3'd4, 8'h99);
    chk("snd_over_irq", 32'(snd_irq), 32'h1);
    chk("snd_over_cmd", 32'(snd_cmd), 32'h99);

    // Coin counters
    do_reset(); step();
    hi0 = 0; hi1 = 0;
    wr(3'd1, 8'h01); wr(3'd1, 8'h00);
    repeat (30) step();
    chk("coin_short0", 32'(hi0), 32'd8);
    chk("coin_short1", 32'(hi1), 32'd0);
    hi0 = 0; hi1 = 0;
    wr(3'd1, 8'h01);
    repeat (18) step();
    wr(3'd1, 8'h00);
    repeat (30) step();
    chk("coin_long0", 32'(hi0), 32'd20);
    hi0 = 0; hi1 = 0;
    wr(3'd1, 8'h02); wr(3'd1, 8'h00);
    repeat (30) step();
    chk("coin_b1", 32'(hi1), 32'd8);
    chk("coin_b1_b0", 32'(hi0), 32'd0);
    hi0 = 0; hi1 = 0;
    wr(3'd1, 8'h01); wr(3'd1, 8'h00); wr(3'd1, 8'h01); wr(3'd1, 8'h00);
    repeat (30) step();
    chk("coin_norestart", 32'(hi0), 32'd8);

    // Watchdog free-running
    do_reset();
    pulses = 0; first = 0;
    for (int j = 1; j <= 64; j++) begin
      step();
      if (wdt_rst) begin pulses++; if (first == 0) first = j; end
    end
    chk("wdt_first", 32'(first), 32'd16);
    chk("wdt_count", 32'(pulses), 32'd4);

    // Kick on the expiry cycle
    do_reset();
    repeat (15) step();
    iocs_n = 1'b0; rw = 1'b0; addr = 3'd1; din = 8'h00;
    step();
    iocs_n = 1'b1;
    chk("wdt_kick_exp", 32'(wdt_rst), 32'h0);
    pulses = 0; first = 0;
    for (int j = 17; j <= 40; j++) begin
      step();
      if (wdt_rst) begin pulses++; if (first == 0) first = j; end
    end
    chk("wdt_kick_next", 32'(first), 32'd32);
    chk("wdt_kick_cnt", 32'(pulses), 32'd1);

    // Asynchronous reset mid-count
    do_reset(); step();
    wr(3'd0, 8'h5A);
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", 32'(ctrl), 32'h00);
    step();
    rst_n = 1'b1;
    pulses = 0; first = 0;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (wdt_rst) begin pulses++; if (first == 0) first = j; end
    end
    chk("arst_wdt_first", 32'(first), 32'd16);

    // Strobe already low when reset releases
    iocs_n = 1'b0; rw = 1'b0; addr = 3'd0; din = 8'h77;
    do_reset();
    repeat (5) step();
    chk("held_cs_ctrl", 32'(ctrl), 32'h00);
    iocs_n = 1'b1;
    step();

    // Random traffic against the model
    iocs_n = 1'b1;
    do_reset();
    chk_model = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      iocs_n  = 1'($urandom_range(0, 1));
      rw      = 1'($urandom_range(0, 1));
      addr    = 3'($urandom_range(0, 7));
      din     = 8'($urandom);
      snd_ack = ($urandom_range(0, 7) == 0);
      p1 = 8'($urandom); p2 = 8'($urandom);
      dsw1 = 8'($urandom); dsw2 = 8'($urandom); dsw3 = 4'($urandom);
      rst_n = (i != 1000);
      step();
    end
    rst_n = 1'b1;
    chk_model = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
